alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Keeps the same opcode map for ops 000–100.
- Adds a WIDTH-generic datapath, an internal accumulator, a multi-cycle shift-add multiplier and a valid/ready handshake on both sides.
- Sits between the processor's operand-fetch stage and the writeback register.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_seq.sv | 147 ++++++++++++++
 tb/tb_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map and FSM encoding for the registered ALU.
package alu_pkg;

  localparam logic [2:0] OP_PASS_A = 3'b000;
  localparam logic [2:0] OP_CMP    = 3'b001;
  localparam logic [2:0] OP_PASS_B = 3'b010;
  localparam logic [2:0] OP_ADD    = 3'b011;
  localparam logic [2:0] OP_NOR    = 3'b100;
  localparam logic [2:0] OP_AND    = 3'b101;
  localparam logic [2:0] OP_MUL    = 3'b110;
  localparam logic [2:0] OP_ACC    = 3'b111;

  typedef enum logic {StIdle, StMul} alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand-side and result-side valid/ready bundle of alu_seq.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       f;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             c_out;
  logic             zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, f, out_ready,
    input  in_ready, out_valid, y, c_out, zero, acc
  );

  modport slave (
    input  in_valid, a, b, f, out_ready,
    output in_ready, out_valid, y, c_out, zero, acc
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// product is valid in the cycle done is high (it is the final step's sum).
module alu_mul_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] part_q;
  logic [2*WIDTH-1:0] part_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;

  always_comb begin
    part_d = part_q + (mplier_q[0] ? mcand_q : '0);
    done   = busy_q && (cnt_q == CntW'(WIDTH - 1));
  end

  assign product = part_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      part_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      part_q   <= '0;
      mplier_q <= b;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      part_q   <= part_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-generic ALU with accumulator and valid/ready on both sides.
// Define ALU_SEQ_MUL_EN to build the multi-cycle multiplier for opcode 110.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_RESET = 0
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);

  logic               accept;
  logic               consume;
  logic               single_op;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     alu_wide;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;

  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               c_q, c_d;
  logic               zero_q, zero_d;
  logic               valid_q, valid_d;

  assign accept  = bus.in_valid && bus.in_ready;
  assign consume = valid_q && bus.out_ready;

`ifdef ALU_SEQ_MUL_EN
  alu_state_e state_q, state_d;
  logic       mul_start;

  assign mul_start    = accept && (bus.f == OP_MUL);
  assign single_op    = accept && (bus.f != OP_MUL);
  assign bus.in_ready = (state_q == StIdle) && (!valid_q || bus.out_ready);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mul_start) state_d = StMul;
      StMul:   if (mul_done)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end
`else
  assign single_op    = accept;
  assign mul_done     = 1'b0;
  assign mul_product  = '0;
  assign bus.in_ready = !valid_q || bus.out_ready;
`endif

  // Single-cycle datapath; OP_MUL lands in default and yields zero when handled here.
  always_comb begin
    alu_wide = '0;
    alu_y    = '0;
    alu_c    = 1'b0;
    case (bus.f)
      OP_PASS_A: alu_y = bus.a;
      OP_CMP: begin
        alu_wide = {1'b0, bus.a} - {1'b0, bus.b};
        alu_y    = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_PASS_B: alu_y = bus.b;
      OP_ADD: begin
        alu_wide = {1'b0, bus.a} + {1'b0, bus.b};
        alu_y    = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_NOR: alu_y = ~(bus.a | bus.b);
      OP_AND: alu_y = bus.a & bus.b;
      OP_ACC: begin
        alu_wide = {1'b0, acc_q} + {1'b0, bus.a};
        alu_y    = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      default: alu_y = '0;
    endcase
  end

  // A new result may replace the one being consumed in the same cycle.
  always_comb begin
    y_d     = y_q;
    c_d     = c_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    if (consume) valid_d = 1'b0;
    if (single_op) begin
      y_d     = alu_y;
      c_d     = alu_c;
      zero_d  = (alu_y == '0);
      valid_d = 1'b1;
    end
    if (mul_done) begin
      y_d     = mul_product[WIDTH-1:0];
      c_d     = |mul_product[2*WIDTH-1:WIDTH];
      zero_d  = (mul_product[WIDTH-1:0] == '0);
      valid_d = 1'b1;
    end
    if (accept && (bus.f == OP_ACC)) acc_d = alu_y;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q     <= '0;
      c_q     <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
      acc_q   <= WIDTH'(ACC_RESET);
    end else begin
      y_q     <= y_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.y         = y_q;
  assign bus.c_out     = c_q;
  assign bus.zero      = zero_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4; multiply checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(4)) bus ();

  alu_seq #(
    .WIDTH     (4),
    .ACC_RESET (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] y;
    logic       c;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input logic [3:0] y, input logic c, input logic z);
    exp_t e;
    e.y = y; e.c = c; e.z = z;
    exp_q.push_back(e);
  endtask

  // Presents an op from posedge+1 until accepted; returns at posedge+1 after acceptance.
  task automatic issue(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b,
                       output bit ok);
    bus.f = f; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat counts negedges, 99 on timeout.
  task automatic wait_result(output logic [3:0] y, output logic c, output logic z,
                             output int lat);
    bit seen = 1'b0;
    lat = 99; y = 'x; c = 'x; z = 'x;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1; lat = i; y = bus.y; c = bus.c_out; z = bus.zero;
      end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.f = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.y, bus.c_out, bus.zero} !== {1'b0, 4'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b y=%h c=%b z=%b want v=0 y=0 c=0 z=1",
               bus.out_valid, bus.y, bus.c_out, bus.zero);
    end
    n_cmp++;
    if (bus.acc !== 4'h0) begin
      n_bad++; $display("FAIL reset_acc: got %h want 0", bus.acc);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    bit ok; logic [3:0] y; logic c, z; int lat; exp_t e;
    issue(OP_ADD, 4'd9, 4'd8, ok);
    push(4'h1, 1'b1, 1'b0);
    wait_result(y, c, z, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if ({y, c, z} !== {e.y, e.c, e.z}) begin
      n_bad++; $display("FAIL add_9_8: got y=%h c=%b z=%b want y=%h c=%b z=%b",
                        y, c, z, e.y, e.c, e.z);
    end
    n_cmp++;
    if (lat !== 1 || !ok) begin
      n_bad++; $display("FAIL add_latency: got %0d (accepted=%b) want 1", lat, ok);
    end
  endtask

  task automatic test_compare();
    bit ok; logic [3:0] y; logic c, z; int lat; exp_t e;
    logic [3:0] av [2] = '{4'd3, 4'd5};
    logic [3:0] bv [2] = '{4'd5, 4'd5};
    push(4'hE, 1'b1, 1'b0);
    push(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      issue(OP_CMP, av[i], bv[i], ok);
      wait_result(y, c, z, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if ({y, c, z} !== {e.y, e.c, e.z} || lat !== 1) begin
        n_bad++; $display("FAIL cmp_%0d: got y=%h c=%b z=%b lat=%0d want y=%h c=%b z=%b lat=1",
                          i, y, c, z, lat, e.y, e.c, e.z);
      end
    end
  endtask

  task automatic test_mul();
    bit ok; logic [3:0] y; logic c, z; int lat; exp_t e; bit seen;
`ifdef ALU_SEQ_MUL_EN
    issue(OP_MUL, 4'd3, 4'd5, ok);
    push(4'hF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
        n_bad++; $display("FAIL mul_busy_%0d: got rdy=%b v=%b want rdy=0 v=0",
                          k, bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
    end
    #1;
    wait_result(y, c, z, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if ({y, c, z} !== {e.y, e.c, e.z} || lat !== 1) begin
      n_bad++; $display("FAIL mul_3x5: got y=%h c=%b z=%b lat=%0d want y=%h c=%b z=%b",
                        y, c, z, lat, e.y, e.c, e.z);
    end
    issue(OP_MUL, 4'd6, 4'd5, ok);
    push(4'hE, 1'b1, 1'b0);
    wait_result(y, c, z, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if ({y, c, z} !== {e.y, e.c, e.z} || lat !== 5) begin
      n_bad++; $display("FAIL mul_6x5: got y=%h c=%b z=%b lat=%0d want y=%h c=%b z=%b lat=5",
                        y, c, z, lat, e.y, e.c, e.z);
    end
    // Reset partway through a multiply must discard it.
    issue(OP_MUL, 4'd7, 4'd7, ok);
    @(negedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.acc} !== {1'b0, 1'b1, 4'h0}) begin
      n_bad++; $display("FAIL mul_reset: got v=%b rdy=%b acc=%h want v=0 rdy=1 acc=0",
                        bus.out_valid, bus.in_ready, bus.acc);
    end
    @(posedge clk); #1 reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
      @(posedge clk);
    end
    #1;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL mul_discard: got result after reset=%b want 0", seen);
    end
`else
    issue(OP_MUL, 4'd3, 4'd5, ok);
    push(4'h0, 1'b0, 1'b1);
    wait_result(y, c, z, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if ({y, c, z} !== {e.y, e.c, e.z} || lat !== 1) begin
      n_bad++; $display("FAIL mul_off: got y=%h c=%b z=%b lat=%0d want y=%h c=%b z=%b lat=1",
                        y, c, z, lat, e.y, e.c, e.z);
    end
    seen = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    bit ok; exp_t e;
    bus.out_ready = 1'b0;
    issue(OP_ADD, 4'd1, 4'd1, ok);
    push(4'h2, 1'b0, 1'b0);
    bus.f = OP_ADD; bus.a = 4'd2; bus.b = 4'd3; bus.in_valid = 1'b1;
    push(4'h5, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.y, bus.in_ready} !== {1'b1, 4'h2, 1'b0}) begin
        n_bad++; $display("FAIL stall_%0d: got v=%b y=%h rdy=%b want v=1 y=2 rdy=0",
                          k, bus.out_valid, bus.y, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.in_ready, bus.y, bus.c_out, bus.zero} !== {1'b1, e.y, e.c, e.z}) begin
      n_bad++; $display("FAIL stall_release: got rdy=%b y=%h c=%b z=%b want rdy=1 y=%h c=%b z=%b",
                        bus.in_ready, bus.y, bus.c_out, bus.zero, e.y, e.c, e.z);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.out_valid, bus.y, bus.c_out, bus.zero} !== {1'b1, e.y, e.c, e.z}) begin
      n_bad++; $display("FAIL stall_second: got v=%b y=%h c=%b z=%b want v=1 y=%h c=%b z=%b",
                        bus.out_valid, bus.y, bus.c_out, bus.zero, e.y, e.c, e.z);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_accumulate();
    bit ok; logic [3:0] y; logic c, z; int lat; exp_t e;
    logic [2:0] fv   [4] = '{OP_ACC, OP_ACC, OP_ADD, OP_ACC};
    logic [3:0] av   [4] = '{4'd7, 4'd7, 4'd1, 4'd7};
    logic [3:0] bv   [4] = '{4'd0, 4'd0, 4'd2, 4'd0};
    logic [3:0] accv [4] = '{4'h7, 4'hE, 4'hE, 4'h5};
    logic [3:0] macc = 4'h0;
    logic [4:0] sum;
    for (int i = 0; i < 4; i++) begin
      sum = (fv[i] == OP_ACC) ? ({1'b0, macc} + {1'b0, av[i]}) : ({1'b0, av[i]} + {1'b0, bv[i]});
      if (fv[i] == OP_ACC) macc = sum[3:0];
      issue(fv[i], av[i], bv[i], ok);
      push(sum[3:0], sum[4], sum[3:0] == 4'h0);
      wait_result(y, c, z, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if ({y, c, z, bus.acc} !== {e.y, e.c, e.z, accv[i]}) begin
        n_bad++; $display("FAIL acc_%0d: got y=%h c=%b z=%b acc=%h want y=%h c=%b z=%b acc=%h",
                          i, y, c, z, bus.acc, e.y, e.c, e.z, accv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0] fv [5] = '{OP_NOR, OP_AND, OP_PASS_A, OP_PASS_B, OP_NOR};
    logic [3:0] av [5] = '{4'h5, 4'hC, 4'h9, 4'h3, 4'hF};
    logic [3:0] bv [5] = '{4'h3, 4'h3, 4'h1, 4'h6, 4'h0};
    logic [3:0] yv [5] = '{4'h8, 4'h0, 4'h9, 4'h6, 4'h0};
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        bus.f = fv[i]; bus.a = av[i]; bus.b = bv[i]; bus.in_valid = 1'b1;
        push(yv[i], 1'b0, yv[i] == 4'h0);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 5) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_bad++; $display("FAIL b2b_ready_%0d: got %b want 1", i, bus.in_ready);
        end
      end
      if (i > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_valid, bus.y, bus.c_out, bus.zero} !== {1'b1, e.y, e.c, e.z}) begin
          n_bad++; $display("FAIL b2b_%0d: got v=%b y=%h c=%b z=%b want v=1 y=%h c=%b z=%b",
                            i - 1, bus.out_valid, bus.y, bus.c_out, bus.zero, e.y, e.c, e.z);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_compare();
    test_mul();
    test_backpressure();
    test_accumulate();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
